// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared types for the pipeline stall/flush sequencer.
//   pctl_state_t : split I/D miss tracking state.
//   stage_en_t   : bundle of per-stage load enables, NOP flushes and PC redirect.
//   stage_en_f   : priority decode of redirect/bubble into stage enables.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      PCTL_RUN    = 2'd0,
      PCTL_HOLD_I = 2'd1,
      PCTL_HOLD_D = 2'd2
   } pctl_state_t;

   typedef struct packed {
      logic pc_sel_redirect;
      logic ld_pc;
      logic ld_if_id;
      logic ld_id_ex;
      logic ld_ex_mem;
      logic ld_mem_wb;
      logic flush_if_id;
      logic flush_id_ex;
   } stage_en_t;

   localparam stage_en_t STAGE_EN_NONE = '0;

   // A redirect wins over a bubble: the instruction the bubble would hold
   // in ID is on the wrong path and gets flushed anyway.
   function automatic stage_en_t stage_en_f(input logic adv,
                                            input logic br_redirect,
                                            input logic bubble);
      stage_en_t en;
      en = STAGE_EN_NONE;
      if (adv) begin
         if (br_redirect) begin
            en.pc_sel_redirect = 1'b1;
            en.ld_pc           = 1'b1;
            en.ld_if_id        = 1'b1;
            en.ld_id_ex        = 1'b1;
            en.ld_ex_mem       = 1'b1;
            en.ld_mem_wb       = 1'b1;
            en.flush_if_id     = 1'b1;
            en.flush_id_ex     = 1'b1;
         end else if (bubble) begin
            en.ld_id_ex        = 1'b1;
            en.flush_id_ex     = 1'b1;
            en.ld_ex_mem       = 1'b1;
            en.ld_mem_wb       = 1'b1;
         end else begin
            en.ld_pc           = 1'b1;
            en.ld_if_id        = 1'b1;
            en.ld_id_ex        = 1'b1;
            en.ld_ex_mem       = 1'b1;
            en.ld_mem_wb       = 1'b1;
         end
      end
      return en;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// pipeline_ctrl_sat_counter
//   Saturating up-counter used for optional pipeline performance statistics.
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   inc        : count this cycle
//   count      : current value, sticks at all-ones once reached
module pipeline_ctrl_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central stall/flush sequencer for the 5-stage RV32I pipeline. Merges the
//   load-use bubble, split I/D cache miss handshakes and EX branch redirect
//   into stage register load enables and NOP flushes. A fetch or load that
//   completes while the other side is still missing is parked in a hold
//   buffer (ibuf/dbuf) rather than reissued.
//
//   Build option: define PIPELINE_CTRL_PERF_EN to add four CNT_W-bit
//   saturating performance counters as extra output ports.
//
//   Ports
//     clk, rst_n          clock, async active-low reset
//     bubble              load-use stall request
//     imem_req/imem_resp  IF fetch request / I-cache response pulse
//     dmem_req/dmem_resp  MEM load/store present / D-cache response pulse
//     br_redirect         EX resolved taken branch
//     imem_read           gated fetch strobe
//     dmem_access         gated data access strobe
//     ibuf_ld/ibuf_sel    capture / use held fetch data
//     dbuf_ld/dbuf_sel    capture / use held load data
//     pc_sel_redirect     PC mux selects branch target
//     ld_*                stage register load enables
//     flush_if_id/id_ex   load NOP into IF/ID, ID/EX
//     cnt_* (perf build)  istall, dstall, bubble, flush event counts
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   RUN     | nothing held; both sides free to advance or miss
//   HOLD_I  | fetch response captured in ibuf, waiting on D-cache
//   HOLD_D  | load response captured in dbuf, waiting on I-cache
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic bubble,
   input  logic imem_req,
   input  logic imem_resp,
   input  logic dmem_req,
   input  logic dmem_resp,
   input  logic br_redirect,
   output logic imem_read,
   output logic dmem_access,
   output logic ibuf_ld,
   output logic ibuf_sel,
   output logic dbuf_ld,
   output logic dbuf_sel,
   output logic pc_sel_redirect,
   output logic ld_pc,
   output logic ld_if_id,
   output logic ld_id_ex,
   output logic ld_ex_mem,
   output logic ld_mem_wb,
   output logic flush_if_id,
   output logic flush_id_ex
`ifdef PIPELINE_CTRL_PERF_EN
  ,output logic [CNT_W-1:0] cnt_istall,
   output logic [CNT_W-1:0] cnt_dstall,
   output logic [CNT_W-1:0] cnt_bubble,
   output logic [CNT_W-1:0] cnt_flush
`endif
);

   pctl_state_t state_q;
   pctl_state_t state_d;

   logic      i_done;
   logic      d_done;
   logic      i_pend;
   logic      d_pend;
   logic      adv;
   logic      ibuf_ld_c;
   logic      ibuf_sel_c;
   logic      dbuf_ld_c;
   logic      dbuf_sel_c;
   stage_en_t en;

   assign i_done = (state_q == PCTL_HOLD_I);
   assign d_done = (state_q == PCTL_HOLD_D);

   // A response arriving this cycle already clears the pending condition,
   // so the pipeline advances with no extra cycle of latency.
   assign i_pend = imem_req & ~i_done & ~imem_resp;
   assign d_pend = dmem_req & ~d_done & ~dmem_resp;
   assign adv    = ~i_pend & ~d_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PCTL_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ibuf_ld_c  = 1'b0;
      ibuf_sel_c = 1'b0;
      dbuf_ld_c  = 1'b0;
      dbuf_sel_c = 1'b0;
      case (state_q)
         PCTL_RUN: begin
            // i_pend/d_pend exclude the same-cycle response, so at most one
            // of these can fire; both responses together is a plain advance.
            if (imem_req && imem_resp && d_pend) begin
               state_d   = PCTL_HOLD_I;
               ibuf_ld_c = 1'b1;
            end else if (dmem_req && dmem_resp && i_pend) begin
               state_d   = PCTL_HOLD_D;
               dbuf_ld_c = 1'b1;
            end
         end
         PCTL_HOLD_I: begin
            if (adv) begin
               state_d    = PCTL_RUN;
               ibuf_sel_c = 1'b1;
            end
         end
         PCTL_HOLD_D: begin
            if (adv) begin
               state_d    = PCTL_RUN;
               dbuf_sel_c = 1'b1;
            end
         end
         default: begin
            state_d = PCTL_RUN;
         end
      endcase
   end

   // rst_n is folded into the combinational outputs so nothing reaches the
   // caches or stage registers while reset is held, not just after an edge.
   assign en = stage_en_f(adv & rst_n, br_redirect, bubble);

   assign imem_read       = rst_n & imem_req & ~i_done;
   assign dmem_access     = rst_n & dmem_req & ~d_done;
   assign ibuf_ld         = rst_n & ibuf_ld_c;
   assign ibuf_sel        = rst_n & ibuf_sel_c;
   assign dbuf_ld         = rst_n & dbuf_ld_c;
   assign dbuf_sel        = rst_n & dbuf_sel_c;
   assign pc_sel_redirect = en.pc_sel_redirect;
   assign ld_pc           = en.ld_pc;
   assign ld_if_id        = en.ld_if_id;
   assign ld_id_ex        = en.ld_id_ex;
   assign ld_ex_mem       = en.ld_ex_mem;
   assign ld_mem_wb       = en.ld_mem_wb;
   assign flush_if_id     = en.flush_if_id;
   assign flush_id_ex     = en.flush_id_ex;

`ifdef PIPELINE_CTRL_PERF_EN
   logic inc_istall;
   logic inc_dstall;
   logic inc_bubble;
   logic inc_flush;

   assign inc_istall = i_pend & ~d_pend;
   assign inc_dstall = d_pend;
   assign inc_bubble = adv & bubble & ~br_redirect;
   assign inc_flush  = adv & br_redirect;

   pipeline_ctrl_sat_counter #(.CNT_W(CNT_W)) u_cnt_istall (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_istall),
      .count (cnt_istall)
   );

   pipeline_ctrl_sat_counter #(.CNT_W(CNT_W)) u_cnt_dstall (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_dstall),
      .count (cnt_dstall)
   );

   pipeline_ctrl_sat_counter #(.CNT_W(CNT_W)) u_cnt_bubble (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_bubble),
      .count (cnt_bubble)
   );

   pipeline_ctrl_sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_flush),
      .count (cnt_flush)
   );
`else
   // Counter width only matters when the counters are built.
   if (CNT_W < 1) begin : g_cnt_w_unused
   end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Scoreboard bench for pipeline_ctrl. Each driven cycle is described as a
//   miss "step": which sides request, and the cycle offset at which each
//   cache responds. Expected outputs follow from those offsets directly.
module tb_pipeline_ctrl;

   localparam int CNT_W = 32;

   logic clk;
   logic rst_n;
   logic bubble, imem_req, imem_resp, dmem_req, dmem_resp, br_redirect;
   logic imem_read, dmem_access, ibuf_ld, ibuf_sel, dbuf_ld, dbuf_sel;
   logic pc_sel_redirect, ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb;
   logic flush_if_id, flush_id_ex;
`ifdef PIPELINE_CTRL_PERF_EN
   logic [CNT_W-1:0] cnt_istall, cnt_dstall, cnt_bubble, cnt_flush;
`endif

   pipeline_ctrl #(.CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bubble          (bubble),
      .imem_req        (imem_req),
      .imem_resp       (imem_resp),
      .dmem_req        (dmem_req),
      .dmem_resp       (dmem_resp),
      .br_redirect     (br_redirect),
      .imem_read       (imem_read),
      .dmem_access     (dmem_access),
      .ibuf_ld         (ibuf_ld),
      .ibuf_sel        (ibuf_sel),
      .dbuf_ld         (dbuf_ld),
      .dbuf_sel        (dbuf_sel),
      .pc_sel_redirect (pc_sel_redirect),
      .ld_pc           (ld_pc),
      .ld_if_id        (ld_if_id),
      .ld_id_ex        (ld_id_ex),
      .ld_ex_mem       (ld_ex_mem),
      .ld_mem_wb       (ld_mem_wb),
      .flush_if_id     (flush_if_id),
      .flush_id_ex     (flush_id_ex)
`ifdef PIPELINE_CTRL_PERF_EN
     ,.cnt_istall      (cnt_istall),
      .cnt_dstall      (cnt_dstall),
      .cnt_bubble      (cnt_bubble),
      .cnt_flush       (cnt_flush)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {imem_read, dmem_access, ibuf_ld, ibuf_sel, dbuf_ld, dbuf_sel,
   //  pc_sel_redirect, ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb,
   //  flush_if_id, flush_id_ex}
   logic [13:0] act;
   assign act = {imem_read, dmem_access, ibuf_ld, ibuf_sel, dbuf_ld, dbuf_sel,
                 pc_sel_redirect, ld_pc, ld_if_id, ld_id_ex, ld_ex_mem,
                 ld_mem_wb, flush_if_id, flush_id_ex};

   logic [13:0] exp_q[$];
   string       tag_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   longint      m_istall = 0, m_dstall = 0, m_bubble = 0, m_flush = 0;

   // Monitor: one expectation per driven cycle, compared mid-cycle.
   initial begin
      logic [13:0] e;
      string       t;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_checks++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL %s t=%0t got=%b expected=%b", t, $time, act, e);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout at t=%0t", $time);
      $fatal(1, "timeout");
   end

   function automatic bit pick(input int mode, input int one_in);
      if (mode == 0) return 1'b0;
      if (mode == 1) return 1'b1;
      return ($urandom % one_in) == 0;
   endfunction

   // One pipeline step: requests held until the advance cycle, responses at
   // cycle ilat/dlat. The step ends on the cycle both sides are satisfied.
   // stop_c >= 0 abandons the step before driving cycle stop_c.
   task automatic run_step(input bit ireq, input bit dreq,
                           input int ilat, input int dlat,
                           input int br_mode, input int bub_mode,
                           input int stop_c, input string tag);
      int adv_c;
      int ie, de;
      adv_c = 0;
      ie = ireq ? ilat : 0;
      de = dreq ? dlat : 0;
      adv_c = (ie > de) ? ie : de;
      for (int c = 0; c <= adv_c; c++) begin
         bit ip, dp, adv, br, bub;
         bit [7:0] en;
         if (stop_c >= 0 && c == stop_c) return;
         @(posedge clk);
         #1;
         br  = pick(br_mode, 6);
         bub = pick(bub_mode, 4);
         imem_req    = ireq;
         dmem_req    = dreq;
         imem_resp   = ireq && (c == ilat);
         dmem_resp   = dreq && (c == dlat);
         br_redirect = br;
         bubble      = bub;
         ip  = ireq && (c < ilat);
         dp  = dreq && (c < dlat);
         adv = !ip && !dp;
         // {pc_sel, ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb, fl_if_id, fl_id_ex}
         if (!adv)     en = 8'b0000_0000;
         else if (br)  en = 8'b1111_1111;
         else if (bub) en = 8'b0001_1101;
         else          en = 8'b0111_1100;
         exp_q.push_back({ireq && (c <= ilat),
                          dreq && (c <= dlat),
                          ireq && (c == ilat) && dp,
                          adv && ireq && (ilat < c),
                          dreq && (c == dlat) && ip,
                          adv && dreq && (dlat < c),
                          en});
         tag_q.push_back(tag);
         if (ip && !dp) m_istall++;
         if (dp) m_dstall++;
         if (adv && bub && !br) m_bubble++;
         if (adv && br) m_flush++;
      end
   endtask

   task automatic reset_cycle(input string tag);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.push_back(14'b0);
      tag_q.push_back(tag);
      m_istall = 0; m_dstall = 0; m_bubble = 0; m_flush = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      bubble = 0; imem_req = 0; imem_resp = 0;
      dmem_req = 0; dmem_resp = 0; br_redirect = 0;

      // Held in reset with live requests: everything must stay low.
      @(posedge clk);
      #1;
      imem_req = 1; dmem_req = 1; br_redirect = 1;
      exp_q.push_back(14'b0);
      tag_q.push_back("reset_outputs");
      @(negedge clk);
      #1;
      rst_n = 1'b1;

      for (int k = 0; k < 4; k++) run_step(1, 0, 0, 0, 0, 0, -1, "hit_stream");
      run_step(1, 0, 0, 0, 0, 1, -1, "bubble");
      run_step(1, 0, 0, 0, 0, 0, -1, "after_bubble");
      run_step(1, 1, 5, 8, 0, 0, -1, "imiss5_dmiss8");
      run_step(1, 1, 6, 3, 0, 0, -1, "dresp3_iresp6");
      run_step(1, 1, 4, 4, 0, 0, -1, "same_cycle_resp");
      run_step(1, 0, 4, 0, 1, 1, -1, "redirect_over_miss");
      run_step(0, 1, 0, 3, 1, 0, -1, "dmiss_no_ifetch");

      // Reset while parked in HOLD_I, then a fresh fetch must be issued.
      run_step(1, 1, 2, 6, 0, 0, 4, "pre_reset_hold_i");
      reset_cycle("reset_in_hold_i");
      reset_cycle("reset_held");
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      run_step(1, 0, 2, 0, 0, 0, -1, "fetch_after_reset");

      for (int k = 0; k < 300; k++) begin
         run_step(($urandom % 4) != 0, ($urandom % 2) == 0,
                  $urandom_range(0, 6), $urandom_range(0, 6),
                  2, 2, -1, "random");
      end

      @(posedge clk);
      #1;
      bubble = 0; imem_req = 0; imem_resp = 0;
      dmem_req = 0; dmem_resp = 0; br_redirect = 0;
      repeat (3) @(posedge clk);
      #1;

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
      end

`ifdef PIPELINE_CTRL_PERF_EN
      n_checks++;
      if (cnt_istall !== CNT_W'(m_istall)) begin
         n_fail++;
         $display("FAIL cnt_istall got=%0d expected=%0d", cnt_istall, m_istall);
      end
      n_checks++;
      if (cnt_dstall !== CNT_W'(m_dstall)) begin
         n_fail++;
         $display("FAIL cnt_dstall got=%0d expected=%0d", cnt_dstall, m_dstall);
      end
      n_checks++;
      if (cnt_bubble !== CNT_W'(m_bubble)) begin
         n_fail++;
         $display("FAIL cnt_bubble got=%0d expected=%0d", cnt_bubble, m_bubble);
      end
      n_checks++;
      if (cnt_flush !== CNT_W'(m_flush)) begin
         n_fail++;
         $display("FAIL cnt_flush got=%0d expected=%0d", cnt_flush, m_flush);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Combines three inputs (hazard-unit load-use bubble, I-cache/D-cache miss handshakes, EX-stage branch redirect) into per-stage register load enables and NOP-insertion flushes.
- Tracks split I/D miss completion so a finished fetch or load is held, not reissued, while the other side is still missing.

Parameters:
CNT_W, 32, width of optional performance counters (saturating).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
bubble  in  1  load-use stall request from hazard_unit
imem_req  in  1  IF stage wants a fetch this cycle
imem_resp  in  1  I-cache response pulse (1 cycle)
dmem_req  in  1  MEM stage holds load/store
dmem_resp  in  1  D-cache response pulse (1 cycle)
br_redirect  in  1  EX resolved taken branch/jump; PC must redirect
imem_read  out  1  gated fetch strobe to I-cache
dmem_access  out  1  gated access strobe to D-cache
ibuf_ld  out  1  capture I-cache rdata into IF hold buffer
ibuf_sel  out  1  IF/ID takes instruction from hold buffer
dbuf_ld  out  1  capture D-cache rdata into MEM hold buffer
dbuf_sel  out  1  MEM/WB takes load data from hold buffer
pc_sel_redirect  out  1  PC mux selects branch target
ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb  out  1 each  stage register load enables
flush_if_id, flush_id_ex  out  1 each  load NOP instead of incoming data

Behaviour:
- Async reset (rst_n=0): state=RUN, i_done=d_done=0. While in reset, all outputs are 0.
- i_pend = imem_req & ~i_done & ~imem_resp. d_pend = dmem_req & ~d_done & ~dmem_resp.
- adv = ~i_pend & ~d_pend. The pipeline advances in the same cycle a response arrives (zero added latency).
- imem_read = imem_req & ~i_done. dmem_access = dmem_req & ~d_done.
- FSM state is derived from i_done/d_done and registered. States:
  - RUN: i_done=0, d_done=0.
  - HOLD_I: fetch completed, waiting on D.
  - HOLD_D: load completed, waiting on I.
- Transitions:
  - RUN→HOLD_I: imem_resp while d_pend. Asserts ibuf_ld, sets i_done.
  - RUN→HOLD_D: dmem_resp while i_pend. Asserts dbuf_ld, sets d_done.
  - HOLD_I→RUN: on adv (dmem_resp). ibuf_sel=1 that cycle.
  - HOLD_D→RUN: on adv (imem_resp). dbuf_sel=1 that cycle.
  - Same-cycle imem_resp and dmem_resp: adv; stay RUN.
  - HOLD_I and HOLD_D are never simultaneous.
- Enables when adv=0: all ld_*=0, flush_*=0, pc_sel_redirect=0.
- Enables when adv=1 (priority order):
  - br_redirect: ld_*=1, pc_sel_redirect=1, flush_if_id=1, flush_id_ex=1. Overrides bubble, because the stalled instruction is wrong-path.
  - else bubble: ld_pc=0, ld_if_id=0, ld_id_ex=1 with flush_id_ex=1, ld_ex_mem=1, ld_mem_wb=1.
  - else: all ld_*=1, flushes 0.
- br_redirect during a miss is not acted on until adv. EX holds the branch, so br_redirect stays asserted; the wrong-path fetch completes and is discarded by flush_if_id.
- imem_req=0 or dmem_req=0 counts as not pending.
- Reset mid-miss returns to RUN and clears hold flags. Caches are reset concurrently.

Optional Feature:
- PIPELINE_CTRL_PERF_EN defined: adds CNT_W-bit saturating counters, reset 0.
  - cnt_istall: cycles i_pend & ~d_pend.
  - cnt_dstall: cycles d_pend.
  - cnt_bubble: adv & bubble & ~br_redirect.
  - cnt_flush: adv & br_redirect.
  - Exposed as output ports; each holds at all-ones once saturated.
- Undefined: counters and ports absent; behaviour otherwise identical.

Decomposition:
- Add pctl_state_t enum (RUN, HOLD_I, HOLD_D) and a stage-enable struct typedef to rv32i_types.
- One natural sub-module: sat_counter (CNT_W, inc in, count out), instantiated 4× under the macro.

Test Plan:
- No hazards, imem_req=1, resp every cycle, dmem_req=0 → all ld_*=1 every cycle; flushes 0; state RUN.
- bubble=1 for 1 cycle with adv → ld_pc=0, ld_if_id=0, flush_id_ex=1, ld_ex_mem=ld_mem_wb=1; next cycle normal.
- I-miss 5 cycles, D-miss 8 cycles, both start cycle 0 →
  - imem_resp cycle 5: ibuf_ld=1, state HOLD_I, imem_read=0 cycles 6–8.
  - dmem_resp cycle 8: adv, ibuf_sel=1, all ld_*=1, state RUN.
- D-resp cycle 3, I-resp cycle 6 → HOLD_D cycles 4–6, dbuf_sel=1 at cycle 6; exactly one advance, at cycle 6.
- br_redirect=1 and bubble=1 during 4-cycle I-miss → no enables until cycle 4; then pc_sel_redirect=1, flush_if_id=flush_id_ex=1, ld_pc=1.
- rst_n dropped in HOLD_I → outputs 0 immediately; after release state RUN, i_done=0, imem_read reasserts with imem_req.
